// File: rtl/axi_mem_pkg.sv
// Shared response codes and FSM state types for the multi-read-channel AXI memory slave.
package axi_mem_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_DATA = 2'd1,
        W_RESP = 2'd2
    } wr_state_t;

    typedef enum logic {
        R_IDLE = 1'b0,
        R_DATA = 1'b1
    } rd_state_t;

    function automatic logic [1:0] resp_for(input logic ok);
        return ok ? RESP_OKAY : RESP_SLVERR;
    endfunction

endpackage

// File: rtl/axi_mem_rd_channel.sv
// One independent AXI read channel; the parent owns the memory and answers the
// channel's current address combinationally through mem_addr/mem_data/mem_hit.
module axi_mem_rd_channel #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ADDR_WIDTH-1:0] araddr,
    input  logic [7:0]            arlen,
    input  logic                  arvalid,
    output logic                  arready,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic [1:0]            rresp,
    output logic                  rlast,
    output logic                  rvalid,
    input  logic                  rready,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [DATA_WIDTH-1:0] mem_data,
    input  logic                  mem_hit
);
    import axi_mem_pkg::*;

    rd_state_t             state;
    rd_state_t             state_next;
    logic [ADDR_WIDTH-1:0] addr;
    logic [7:0]            cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= R_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            R_IDLE:  if (arvalid) state_next = R_DATA;
            R_DATA:  if (rready && (cnt == 8'd0)) state_next = R_IDLE;
            default: state_next = R_IDLE;
        endcase
    end

    always_comb begin
        arready = 1'b0;
        rvalid  = 1'b0;
        rlast   = 1'b0;
        rresp   = RESP_OKAY;
        rdata   = '0;
        case (state)
            R_IDLE: arready = 1'b1;
            R_DATA: begin
                rvalid = 1'b1;
                rlast  = (cnt == 8'd0);
                rresp  = resp_for(mem_hit);
                rdata  = mem_data;
            end
            default: ;
        endcase
    end

    // Address keeps counting past the memory end; only the modulo-2^ADDR_WIDTH wrap applies.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            addr <= '0;
            cnt  <= '0;
        end else if ((state == R_IDLE) && arvalid) begin
            addr <= araddr;
            cnt  <= arlen;
        end else if ((state == R_DATA) && rready && (cnt != 8'd0)) begin
            addr <= addr + ADDR_WIDTH'(1);
            cnt  <= cnt - 8'd1;
        end
    end

    assign mem_addr = addr;

endmodule

// File: rtl/axi_memory_slave_nch.sv
// Word-addressed AXI memory slave: one burst write channel and NUM_RD independent
// burst read channels sharing a register-array memory with combinational read ports.
module axi_memory_slave_nch #(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int MEM_SIZE    = 32,
    parameter int NUM_RD      = 2,
    parameter int INIT_OPTION = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ADDR_WIDTH-1:0] awaddr,
    input  logic                  awvalid,
    output logic                  awready,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  wlast,
    input  logic                  wvalid,
    output logic                  wready,
    output logic [1:0]            bresp,
    output logic                  bvalid,
    input  logic                  bready,
    input  logic [ADDR_WIDTH-1:0] araddr  [NUM_RD],
    input  logic [7:0]            arlen   [NUM_RD],
    input  logic [NUM_RD-1:0]     arvalid,
    output logic [NUM_RD-1:0]     arready,
    output logic [DATA_WIDTH-1:0] rdata   [NUM_RD],
    output logic [1:0]            rresp   [NUM_RD],
    output logic [NUM_RD-1:0]     rlast,
    output logic [NUM_RD-1:0]     rvalid,
    input  logic [NUM_RD-1:0]     rready
);
    import axi_mem_pkg::*;

    localparam int                    IDX_W     = (MEM_SIZE > 1) ? $clog2(MEM_SIZE) : 1;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(MEM_SIZE - 1);

    function automatic logic in_range(input logic [ADDR_WIDTH-1:0] a);
        return a <= LAST_ADDR;
    endfunction

    logic [DATA_WIDTH-1:0] mem [MEM_SIZE];

    wr_state_t             wr_state;
    wr_state_t             wr_state_next;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic                  wr_err;
    logic                  wr_beat;

    assign wr_beat = (wr_state == W_DATA) && wvalid;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_state <= W_IDLE;
        end else begin
            wr_state <= wr_state_next;
        end
    end

    always_comb begin
        wr_state_next = wr_state;
        case (wr_state)
            W_IDLE:  if (awvalid) wr_state_next = W_DATA;
            W_DATA:  if (wvalid && wlast) wr_state_next = W_RESP;
            W_RESP:  if (bready) wr_state_next = W_IDLE;
            default: wr_state_next = W_IDLE;
        endcase
    end

    always_comb begin
        awready = 1'b0;
        wready  = 1'b0;
        bvalid  = 1'b0;
        bresp   = RESP_OKAY;
        case (wr_state)
            W_IDLE: awready = 1'b1;
            W_DATA: wready  = 1'b1;
            W_RESP: begin
                bvalid = 1'b1;
                bresp  = resp_for(!wr_err);
            end
            default: ;
        endcase
    end

    // Out-of-range beats are dropped but still advance the address and poison the burst.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_addr <= '0;
            wr_err  <= 1'b0;
            for (int i = 0; i < MEM_SIZE; i++) begin
                mem[i] <= (INIT_OPTION == 1) ? DATA_WIDTH'(i) : '0;
            end
        end else begin
            if ((wr_state == W_IDLE) && awvalid) begin
                wr_addr <= awaddr;
            end else if (wr_beat) begin
                wr_addr <= wr_addr + ADDR_WIDTH'(1);
            end

            if (wr_beat && in_range(wr_addr)) begin
                mem[wr_addr[IDX_W-1:0]] <= wdata;
            end

            if (wr_beat && !in_range(wr_addr)) begin
                wr_err <= 1'b1;
            end else if ((wr_state == W_RESP) && bready) begin
                wr_err <= 1'b0;
            end
        end
    end

    // Each channel reads the array before this edge's write lands, giving read-old-data on collision.
    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [ADDR_WIDTH-1:0] rd_addr;
        logic                  rd_hit;
        logic [DATA_WIDTH-1:0] rd_word;

        assign rd_hit  = in_range(rd_addr);
        assign rd_word = rd_hit ? mem[rd_addr[IDX_W-1:0]] : '0;

        axi_mem_rd_channel #(
            .ADDR_WIDTH (ADDR_WIDTH),
            .DATA_WIDTH (DATA_WIDTH)
        ) u_rd (
            .clk      (clk),
            .rst_n    (rst_n),
            .araddr   (araddr[k]),
            .arlen    (arlen[k]),
            .arvalid  (arvalid[k]),
            .arready  (arready[k]),
            .rdata    (rdata[k]),
            .rresp    (rresp[k]),
            .rlast    (rlast[k]),
            .rvalid   (rvalid[k]),
            .rready   (rready[k]),
            .mem_addr (rd_addr),
            .mem_data (rd_word),
            .mem_hit  (rd_hit)
        );
    end

endmodule

// File: tb/tb_axi_memory_slave_nch.sv
// Bench for axi_memory_slave_nch: transaction-level reference model compared every
// cycle, directed scenarios with literal expectations, then randomized traffic.
module tb_axi_memory_slave_nch;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int MS = 32;
    localparam int NR = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [AW-1:0] awaddr;
    logic          awvalid;
    logic          awready;
    logic [DW-1:0] wdata;
    logic          wlast;
    logic          wvalid;
    logic          wready;
    logic [1:0]    bresp;
    logic          bvalid;
    logic          bready;
    logic [AW-1:0] araddr [NR];
    logic [7:0]    arlen  [NR];
    logic [NR-1:0] arvalid;
    logic [NR-1:0] arready;
    logic [DW-1:0] rdata  [NR];
    logic [1:0]    rresp  [NR];
    logic [NR-1:0] rlast;
    logic [NR-1:0] rvalid;
    logic [NR-1:0] rready;

    always #5 clk = ~clk;

    axi_memory_slave_nch #(
        .ADDR_WIDTH  (AW),
        .DATA_WIDTH  (DW),
        .MEM_SIZE    (MS),
        .NUM_RD      (NR),
        .INIT_OPTION (1)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .awaddr  (awaddr),
        .awvalid (awvalid),
        .awready (awready),
        .wdata   (wdata),
        .wlast   (wlast),
        .wvalid  (wvalid),
        .wready  (wready),
        .bresp   (bresp),
        .bvalid  (bvalid),
        .bready  (bready),
        .araddr  (araddr),
        .arlen   (arlen),
        .arvalid (arvalid),
        .arready (arready),
        .rdata   (rdata),
        .rresp   (rresp),
        .rlast   (rlast),
        .rvalid  (rvalid),
        .rready  (rready)
    );

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%0h expected=%0h", name, cyc, got, exp);
        end
    endtask

    // Reference model: memory contents, outstanding write burst, outstanding read bursts.
    logic [31:0] m_mem [MS];
    int          m_wph;          // 0 no burst, 1 taking data, 2 response owed
    logic [31:0] m_waddr;
    logic        m_werr;
    logic        m_ract  [NR];
    logic [31:0] m_raddr [NR];
    int          m_rleft [NR];
    logic        model_ok = 1'b0;

    always @(posedge clk) begin
        cyc++;
        if (!rst_n) begin
            for (int i = 0; i < MS; i++) m_mem[i] = i;
            m_wph = 0; m_waddr = 0; m_werr = 1'b0;
            for (int k = 0; k < NR; k++) begin
                m_ract[k] = 1'b0; m_raddr[k] = 0; m_rleft[k] = 0;
            end
            model_ok = 1'b1;
        end else begin
            for (int k = 0; k < NR; k++) begin
                if (!m_ract[k]) begin
                    if (arvalid[k]) begin
                        m_ract[k] = 1'b1; m_raddr[k] = araddr[k]; m_rleft[k] = int'(arlen[k]);
                    end
                end else if (rready[k]) begin
                    if (m_rleft[k] == 0) m_ract[k] = 1'b0;
                    else begin m_raddr[k] = m_raddr[k] + 1; m_rleft[k] = m_rleft[k] - 1; end
                end
            end
            if (m_wph == 0) begin
                if (awvalid) begin m_waddr = awaddr; m_wph = 1; end
            end else if (m_wph == 1) begin
                if (wvalid) begin
                    if (m_waddr < MS) m_mem[m_waddr] = wdata;
                    else m_werr = 1'b1;
                    m_waddr = m_waddr + 1;
                    if (wlast) m_wph = 2;
                end
            end else begin
                if (bready) begin m_wph = 0; m_werr = 1'b0; end
            end
        end
    end

    always @(negedge clk) begin
        logic [31:0] ed;
        logic        hit;
        if (model_ok) begin
            chk("awready", awready, m_wph == 0);
            chk("wready", wready, m_wph == 1);
            chk("bvalid", bvalid, m_wph == 2);
            chk("bresp", bresp, (m_wph == 2 && m_werr) ? 2'b10 : 2'b00);
            for (int k = 0; k < NR; k++) begin
                chk($sformatf("arready%0d", k), arready[k], !m_ract[k]);
                chk($sformatf("rvalid%0d", k), rvalid[k], m_ract[k]);
                if (m_ract[k]) begin
                    hit = m_raddr[k] < MS;
                    if (hit) ed = m_mem[m_raddr[k]];
                    else ed = 32'h0;
                    chk($sformatf("rdata%0d", k), rdata[k], ed);
                    chk($sformatf("rresp%0d", k), rresp[k], hit ? 2'b00 : 2'b10);
                    chk($sformatf("rlast%0d", k), rlast[k], m_rleft[k] == 0);
                end else begin
                    chk($sformatf("rlast%0d", k), rlast[k], 1'b0);
                    chk($sformatf("rresp%0d", k), rresp[k], 2'b00);
                end
            end
        end
    end

    typedef struct {
        logic [31:0] d;
        logic [1:0]  r;
        logic        l;
        int          c;
    } beat_t;

    beat_t      cap0 [$];
    beat_t      cap1 [$];
    logic [1:0] bcap [$];

    always @(negedge clk) begin
        if (rvalid[0] && rready[0]) cap0.push_back('{rdata[0], rresp[0], rlast[0], cyc});
        if (rvalid[1] && rready[1]) cap1.push_back('{rdata[1], rresp[1], rlast[1], cyc});
        if (bvalid && bready) bcap.push_back(bresp);
    end

    function automatic int capn(input int ch);
        return (ch == 0) ? cap0.size() : cap1.size();
    endfunction

    function automatic beat_t getb(input int ch, input int j);
        beat_t b;
        b.d = 'x; b.r = 'x; b.l = 1'bx; b.c = -1;
        if (ch == 0 && j < cap0.size()) b = cap0[j];
        if (ch == 1 && j < cap1.size()) b = cap1[j];
        return b;
    endfunction

    function automatic logic [1:0] getbr(input int j);
        if (j < bcap.size()) return bcap[j];
        return 2'bxx;
    endfunction

    function automatic logic [31:0] rand_addr();
        if ($urandom_range(0, 15) == 0) return 32'hFFFF_FFFF - 32'($urandom_range(0, 3));
        return 32'($urandom_range(0, 35));
    endfunction

    logic [31:0] wbuf [4];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        cap0.delete(); cap1.delete(); bcap.delete();
    endtask

    task automatic idle_in();
        awvalid = 1'b0; awaddr = '0; wvalid = 1'b0; wlast = 1'b0; wdata = '0; bready = 1'b1;
        arvalid = '0; rready = '1;
        for (int k = 0; k < NR; k++) begin araddr[k] = '0; arlen[k] = '0; end
    endtask

    task automatic do_reset();
        idle_in();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        clr();
    endtask

    task automatic do_write(input logic [31:0] addr, input int n, input bit wait_b);
        int nb;
        nb = bcap.size();
        awaddr = addr; awvalid = 1'b1;
        for (int i = 0; i < 20 && !awready; i++) tick();
        tick();
        awvalid = 1'b0;
        for (int j = 0; j < n; j++) begin
            wdata = wbuf[j]; wlast = (j == n - 1); wvalid = 1'b1;
            for (int i = 0; i < 20 && !wready; i++) tick();
            tick();
        end
        wvalid = 1'b0; wlast = 1'b0;
        if (wait_b) begin
            for (int i = 0; i < 20 && bcap.size() == nb; i++) tick();
            chk("write_resp_seen", bcap.size(), nb + 1);
        end
    endtask

    task automatic do_read(input int ch, input logic [31:0] addr, input logic [7:0] len);
        araddr[ch] = addr; arlen[ch] = len; arvalid[ch] = 1'b1;
        for (int i = 0; i < 20 && !arready[ch]; i++) tick();
        tick();
        arvalid[ch] = 1'b0;
    endtask

    task automatic wait_beats(input int ch, input int n, input int bound, input string name);
        for (int i = 0; i < bound && capn(ch) < n; i++) tick();
        chk(name, capn(ch), n);
    endtask

    initial begin
        beat_t       b;
        beat_t       b2;
        logic [35:0] held;
        bit          prev_stall;
        bit          pat [4];

        idle_in();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;

        chk("rst_awready", awready, 1'b1);
        chk("rst_wready", wready, 1'b0);
        chk("rst_bvalid", bvalid, 1'b0);
        chk("rst_bresp", bresp, 2'b00);
        chk("rst_arready", arready, 2'b11);
        chk("rst_rvalid", rvalid, 2'b00);
        chk("rst_rlast", rlast, 2'b00);
        chk("rst_rresp0", rresp[0], 2'b00);
        chk("model_init_mem9", m_mem[9], 32'd9);

        // Four-beat write from address 0, then read it back on ch0.
        clr();
        wbuf[0] = 32'hA5A5_A5A5; wbuf[1] = 32'h5A5A_5A5A; wbuf[2] = 32'h1234_5678; wbuf[3] = 32'h8765_4321;
        do_write(32'd0, 4, 1'b1);
        chk("wr4_bresp", getbr(0), 2'b00);
        do_read(0, 32'd0, 8'd3);
        wait_beats(0, 4, 40, "rd4_beats");
        for (int j = 0; j < 4; j++) begin
            b = getb(0, j);
            chk($sformatf("rd4_data%0d", j), b.d, wbuf[j]);
            chk($sformatf("rd4_last%0d", j), b.l, j == 3);
        end
        chk("model_mem2", m_mem[2], 32'h1234_5678);

        // Both channels start on address 4 in the same cycle.
        clr();
        araddr[0] = 32'd4; arlen[0] = 8'd2; araddr[1] = 32'd4; arlen[1] = 8'd0;
        arvalid = 2'b11;
        tick();
        arvalid = 2'b00;
        wait_beats(0, 3, 20, "sim_ch0_beats");
        chk("sim_ch1_beats", cap1.size(), 1);
        b = getb(0, 0); chk("sim_ch0_d0", b.d, 32'd4); chk("sim_ch0_l0", b.l, 1'b0);
        b2 = getb(1, 0); chk("sim_ch1_d0", b2.d, 32'd4); chk("sim_ch1_l0", b2.l, 1'b1);
        chk("sim_same_cycle", b2.c, b.c);
        b = getb(0, 1); chk("sim_ch0_d1", b.d, 32'd5);
        b2 = getb(0, 2); chk("sim_ch0_d2", b2.d, 32'd6); chk("sim_ch0_l2", b2.l, 1'b1);
        b = getb(0, 0);
        chk("sim_no_bubble", b2.c - b.c, 2);

        // ch1 under rready 1,0,0,1 backpressure.
        clr();
        pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b0; pat[3] = 1'b1;
        do_read(1, 32'd10, 8'd3);
        prev_stall = 1'b0;
        held = '0;
        for (int i = 0; i < 40 && cap1.size() < 4; i++) begin
            rready[1] = pat[i % 4];
            if (prev_stall) chk("bp_hold", {rresp[1], rlast[1], 1'b0, rdata[1]}, held);
            held = {rresp[1], rlast[1], 1'b0, rdata[1]};
            prev_stall = rvalid[1] && !rready[1];
            tick();
        end
        rready[1] = 1'b1;
        chk("bp_beats", cap1.size(), 4);
        for (int j = 0; j < 4; j++) begin
            b = getb(1, j);
            chk($sformatf("bp_data%0d", j), b.d, 32'(10 + j));
        end

        // Read beat of address 7 completes on the same edge the write to 7 lands.
        clr();
        rready[0] = 1'b0;
        do_read(0, 32'd7, 8'd0);
        awaddr = 32'd7; awvalid = 1'b1;
        tick();
        awvalid = 1'b0;
        wdata = 32'hDEAD_BEEF; wlast = 1'b1; wvalid = 1'b1; rready[0] = 1'b1;
        tick();
        wvalid = 1'b0; wlast = 1'b0;
        tick();
        tick();
        b = getb(0, 0);
        chk("coll_old_data", b.d, 32'd7);
        clr();
        do_read(0, 32'd7, 8'd0);
        wait_beats(0, 1, 20, "coll_reread_beats");
        b = getb(0, 0);
        chk("coll_new_data", b.d, 32'hDEAD_BEEF);

        // Burst that runs off the end of memory.
        do_reset();
        wbuf[0] = 32'h1111_1111; wbuf[1] = 32'h2222_2222;
        do_write(32'd31, 2, 1'b1);
        chk("oor_bresp", getbr(0), 2'b10);
        do_read(0, 32'd31, 8'd1);
        wait_beats(0, 2, 20, "oor_beats");
        b = getb(0, 0); chk("oor_d0", b.d, 32'h1111_1111); chk("oor_r0", b.r, 2'b00);
        b = getb(0, 1); chk("oor_d1", b.d, 32'h0); chk("oor_r1", b.r, 2'b10); chk("oor_l1", b.l, 1'b1);

        // Address counter wraps at 2^32, not at MEM_SIZE.
        clr();
        do_read(1, 32'hFFFF_FFFE, 8'd3);
        wait_beats(1, 4, 20, "wrap_beats");
        b = getb(1, 0); chk("wrap_r0", b.r, 2'b10);
        b = getb(1, 1); chk("wrap_r1", b.r, 2'b10); chk("wrap_d1", b.d, 32'h0);
        b = getb(1, 2); chk("wrap_r2", b.r, 2'b00); chk("wrap_d2", b.d, 32'd0);
        b = getb(1, 3); chk("wrap_d3", b.d, 32'd1); chk("wrap_l3", b.l, 1'b1);

        // Longest burst.
        clr();
        do_read(1, 32'd0, 8'd255);
        wait_beats(1, 256, 400, "len255_beats");
        b = getb(1, 254); chk("len255_l254", b.l, 1'b0);
        b = getb(1, 255); chk("len255_l255", b.l, 1'b1);
        b = getb(1, 20);  chk("len255_d20", b.d, 32'd20);
        b = getb(1, 224); chk("len255_r224", b.r, 2'b10);

        // Reset during an active read burst and a pending write response.
        do_reset();
        rready[0] = 1'b0;
        do_read(0, 32'd0, 8'd7);
        bready = 1'b0;
        wbuf[0] = 32'h0000_0055;
        do_write(32'd5, 1, 1'b0);
        tick();
        chk("pre_rst_rvalid0", rvalid[0], 1'b1);
        chk("pre_rst_bvalid", bvalid, 1'b1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("midrst_rvalid", rvalid, 2'b00);
        chk("midrst_bvalid", bvalid, 1'b0);
        chk("midrst_arready", arready, 2'b11);
        chk("midrst_awready", awready, 1'b1);
        chk("midrst_wready", wready, 1'b0);
        idle_in();
        tick();

        // Randomized traffic on every channel, including occasional resets.
        for (int n = 0; n < 3000; n++) begin
            awvalid = ($urandom_range(0, 2) == 0);
            awaddr  = rand_addr();
            wvalid  = ($urandom_range(0, 1) == 1);
            wdata   = $urandom();
            wlast   = ($urandom_range(0, 3) == 0);
            bready  = ($urandom_range(0, 2) != 0);
            for (int k = 0; k < NR; k++) begin
                arvalid[k] = ($urandom_range(0, 3) == 0);
                araddr[k]  = rand_addr();
                arlen[k]   = ($urandom_range(0, 60) == 0) ? 8'd255 : 8'($urandom_range(0, 7));
                rready[k]  = ($urandom_range(0, 3) != 0);
            end
            rst_n = ($urandom_range(0, 399) != 0);
            tick();
        end
        rst_n = 1'b1;
        idle_in();
        tick();
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/axi_memory_slave_nch.md
AXI_MEMORY_SLAVE_NCH -- requirements
Module: axi_memory_slave_nch

Interface
REQ-001 Parameter ADDR_WIDTH, default 32, byte-agnostic word address width.
REQ-002 Parameter DATA_WIDTH, default 32, word width.
REQ-003 Parameter MEM_SIZE, default 32, number of words; legal addresses are 0..MEM_SIZE-1.
REQ-004 Parameter NUM_RD, default 2, number of independent read channels (1..8).
REQ-005 Parameter INIT_OPTION, default 0; 0 means all words 0, 1 means mem[i]=i.
REQ-006 The block has one clock and a synchronous, active-low reset; the ports are named clk and rst_n.
REQ-007 clk  in  1  rising-edge clock for all state.
REQ-008 rst_n  in  1  synchronous active-low reset.
REQ-009 awaddr in ADDR_WIDTH, awvalid in 1, awready out 1; this is the write address channel.
REQ-010 wdata in DATA_WIDTH, wlast in 1, wvalid in 1, wready out 1; this is the write data channel.
REQ-011 bresp out 2, bvalid out 1, bready in 1; this is the write response channel.
REQ-012 The per-channel read address ports are araddr in [NUM_RD][ADDR_WIDTH], arlen in [NUM_RD][8], arvalid in [NUM_RD], and arready out [NUM_RD].
REQ-013 The per-channel read data ports are rdata out [NUM_RD][DATA_WIDTH], rresp out [NUM_RD][2], rlast out [NUM_RD], rvalid out [NUM_RD], and rready in [NUM_RD].

Function
REQ-014 The write FSM SHALL have three states, W_IDLE, W_DATA and W_RESP, and SHALL leave reset in W_IDLE.
- W_IDLE: awready=1.
- The AW handshake latches awaddr into wr_addr and moves to W_DATA.
REQ-015 W_DATA SHALL assert wready=1.
- Each wvalid beat writes wdata to mem[wr_addr] at that edge and then increments wr_addr.
- A beat carrying wlast=1 moves the FSM to W_RESP.
REQ-016 A beat with wr_addr>=MEM_SIZE SHALL NOT write memory and SHALL set a sticky error flag for the burst.
REQ-017 W_RESP SHALL assert bvalid=1, with bresp=2'b00 (OKAY) or 2'b10 (SLVERR) if the error flag is set.
- bvalid&&bready returns the FSM to W_IDLE and clears the error flag.
- bvalid holds until bready.
REQ-018 Each read channel k SHALL run an independent FSM with states R_IDLE and R_DATA.
- R_IDLE: arready[k]=1.
- The AR handshake latches the address and the beat counter (=arlen[k]) and moves to R_DATA.
REQ-019 R_DATA SHALL assert rvalid[k]=1 on the cycle after the AR handshake edge (one-cycle latency), with no bubbles between beats while rready[k]=1.
REQ-020 rdata[k] SHALL be the combinational read of mem at the channel's current address; rlast[k]=1 iff the beat counter is 0.
REQ-021 On rvalid[k]&&rready[k]:
- If rlast[k]=1, the channel returns to R_IDLE.
- Otherwise the address increments and the counter decrements.
- With rready[k]=0, rdata, rresp and rlast SHALL hold stable.
REQ-022 A read beat with address>=MEM_SIZE SHALL return rdata=0 and rresp=2'b10; in-range beats return 2'b00.
REQ-023 An arlen of 0 SHALL produce exactly one beat with rlast=1; arlen=255 SHALL produce 256 beats.
REQ-024 Read channels SHALL never stall each other or the write channel.
- All channels may be in R_DATA concurrently.
- Reads of the same address by several channels in one cycle return identical data.
REQ-025 On a write and a read to the same address in the same cycle, the read SHALL return the pre-write data that cycle and the new data from the next cycle.
REQ-026 Address counters SHALL be ADDR_WIDTH wide and SHALL wrap modulo 2^ADDR_WIDTH; there is no wrap at MEM_SIZE.

Reset
REQ-027 A cycle with rst_n=0 SHALL return all FSMs to idle, even mid-burst. The outputs SHALL then be: awready=1, wready=0, bvalid=0, bresp=0, arready=all 1, rvalid=0, rlast=0, rresp=0.
REQ-028 Reset SHALL reinitialise memory per INIT_OPTION and clear the error flag, address counters and beat counters.

Structure
REQ-029 Package axi_mem_pkg SHALL hold the RESP_OKAY/RESP_SLVERR constants and the write/read state enum typedefs.
REQ-030 The read channel SHALL be the sub-module axi_mem_rd_channel, generated NUM_RD times, with a memory read port supplied by the parent.

Verification
REQ-031 Write scenario (INIT_OPTION=1, MEM_SIZE=32, NUM_RD=2):
- Stimulus: AW addr 0, then 4 beats A5A5A5A5, 5A5A5A5A, 12345678, 87654321 with wlast on the 4th.
- Required response: bresp=00.
- A read on ch0 with arlen=3 returns those 4 words, with rlast on beat 4 only.
REQ-032 Simultaneous reads:
- Stimulus: same cycle, ch0 addr 4 arlen 2; ch1 addr 4 arlen 0.
- Required response: ch0 returns 4,5,6; ch1 returns 4 with rlast on its first beat; neither channel stalls.
REQ-033 Backpressure:
- Stimulus: ch1 addr 10 arlen 3, rready toggling 1,0,0,1,...
- Required response: data 10,11,12,13 in order; rdata is held stable while rready=0.
REQ-034 Out-of-range handling:
- Write 2 beats starting at addr 31: word 31 is written, beat 2 is dropped, bresp=10.
- Read addr 31 arlen 1 returns 31's data with rresp 00, then 0 with rresp 10.
REQ-035 Collision:
- Stimulus: ch0 reads addr 7 while a write of DEADBEEF to addr 7 lands that same cycle.
- Required response: that cycle returns 7, and a re-read returns DEADBEEF.
REQ-036 Reset mid-burst:
- Stimulus: rst_n=0 for 1 cycle during a ch0 arlen=7 burst and a pending bvalid.
- Required response: next cycle rvalid=0, bvalid=0, arready=11, awready=1.
